iir_smoothing_filter: RTL and testbench



---
 rtl/iir_smoothing_filter.sv | 110 +++++++++++
 tb/tb_iir_smoothing_filter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_smoothing_filter.sv
// First-order IIR smoothing filter (exponential moving average) on an unsigned sample stream.
// The coefficient is sampled with the sample at input accept; one result is in flight at a time.
module iir_smoothing_filter #(
  parameter int unsigned DATA_W = 12,
  parameter bit          PRIME  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        coefficient,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned ProdW = DATA_W + 9;
  localparam int unsigned SumW  = DATA_W + 10;

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StOut} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_prev_q;
  logic [DATA_W-1:0] out_data_q;
  logic [7:0]        c_q;
  logic [ProdW-1:0]  prod_y_q;
  logic [ProdW-1:0]  prod_x_q;
  logic              primed_q;
  logic              load_q;
  logic              out_valid_q;

  logic [8:0]        c_inv;
  logic [ProdW-1:0]  prod_y_d;
  logic [ProdW-1:0]  prod_x_d;
  logic [SumW-1:0]   sum;
  logic [DATA_W-1:0] y_new;

  always_comb begin
    c_inv    = 9'd256 - {1'b0, c_q};
    prod_y_d = ProdW'(c_q) * ProdW'(y_prev_q);
    prod_x_d = ProdW'(c_inv) * ProdW'(x_q);
    sum      = SumW'(prod_y_q) + SumW'(prod_x_q) + SumW'(128);
    // The weighted sum never exceeds (2^DATA_W-1)*256+128, so dropping the top bits is safe.
    y_new    = load_q ? x_q : sum[DATA_W+7:8];
  end

  // rst and clear gate in_ready directly so no accept can happen in those cycles.
  assign in_ready  = (state_q == StIdle) && !rst && !clear;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      c_q         <= '0;
      prod_y_q    <= '0;
      prod_x_q    <= '0;
      y_prev_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      load_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= StIdle;
      x_q         <= '0;
      c_q         <= '0;
      prod_y_q    <= '0;
      prod_x_q    <= '0;
      y_prev_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q     <= in_data;
            c_q     <= coefficient;
            load_q  <= PRIME && !primed_q;
            state_q <= StMul;
          end
        end
        StMul: begin
          prod_y_q <= prod_y_d;
          prod_x_q <= prod_x_d;
          state_q  <= StAcc;
        end
        StAcc: begin
          y_prev_q    <= y_new;
          out_data_q  <= y_new;
          primed_q    <= 1'b1;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_smoothing_filter.sv
// Bench for iir_smoothing_filter: directed literal cases plus randomized samples against an
// arithmetic EMA model; a compare process checks every valid output cycle.
module tb_iir_smoothing_filter;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [7:0]  coefficient;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;

  int checks;
  int errors;
  int exp_q[$];
  int y_m;
  bit primed_m;

  iir_smoothing_filter #(
    .DATA_W(12),
    .PRIME (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .coefficient(coefficient),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Exponential moving average with rounding, straight from the recurrence.
  function automatic int model_step(input int x, input int c);
    if (!primed_m) y_m = x;
    else y_m = (c * y_m + (256 - c) * x + 128) / 256;
    primed_m = 1'b1;
    return y_m;
  endfunction

  function automatic void model_reset();
    y_m      = 0;
    primed_m = 1'b0;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("out_spurious", out_valid, 0);
      else begin
        chk("out_data", out_data, exp_q[0]);
        chk("in_ready_busy", in_ready, 0);
      end
    end
  end

  task automatic accept(input int x, input int c, input int c_after);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid    = 1'b1;
    in_data     = 12'(x);
    coefficient = 8'(c);
    @(posedge clk);
    exp_q.push_back(model_step(x, c));
    #1;
    in_valid    = 1'b0;
    in_data     = 12'($urandom);
    coefficient = 8'(c_after);
  endtask

  task automatic collect(input int hold, output int got);
    int n;
    logic [11:0] held;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!out_valid && n < 10);
    chk("latency", n, 2);
    held = out_data;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    got = int'(out_data);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    int x;
    int c;
    checks = 0;
    errors = 0;
    model_reset();
    rst         = 1'b1;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    coefficient = '0;
    out_ready   = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Prime then smooth
    accept(2000, 77, 0);
    collect(0, got);
    chk("prime_2000", got, 2000);
    accept(0, 146, 0);
    collect(0, got);
    chk("smooth_1141", got, 1141);

    // Passthrough with c=0, with backpressure on the second sample
    do_clear();
    accept(1000, 0, 0);
    collect(0, got);
    chk("pass_1000", got, 1000);
    accept(37, 0, 0);
    collect(5, got);
    chk("pass_37_bp", got, 37);

    // Max smoothing
    do_clear();
    accept(0, 9, 0);
    collect(0, got);
    chk("max_prime0", got, 0);
    accept(4095, 255, 0);
    collect(0, got);
    chk("max_16", got, 16);
    accept(4095, 255, 0);
    collect(1, got);
    chk("max_32", got, 32);

    // Coefficient change after accept must not affect the sample in flight
    accept(500, 0, 255);
    collect(0, got);
    chk("coef_stable_500", got, 500);

    // Clear while in MUL discards the sample and unprimes the filter
    accept(3000, 100, 100);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    repeat (6) begin
      @(negedge clk);
      chk("clr_no_valid", out_valid, 0);
    end
    accept(300, 200, 0);
    collect(0, got);
    chk("clr_reprime_300", got, 300);

    // Asynchronous reset while in ACC
    accept(3500, 10, 10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release_in_ready", in_ready, 1);
    accept(123, 250, 0);
    collect(0, got);
    chk("arst_reprime_123", got, 123);

    // Randomized samples against the model
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0: c = 0;
        1: c = 255;
        default: c = int'($urandom_range(0, 255));
      endcase
      accept(x, c, int'($urandom_range(0, 255)));
      collect(int'($urandom_range(0, 3)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
